// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: data-memory access, branch/jump resolution, MEM/WB registers
//
// Purpose:
//   Sits directly downstream of execute. Issues the data-memory request for
//   loads/stores over a req/ack handshake. Resolves branches against the BHT
//   prediction and resolves jumps. Drives the global stall (isCacheStall) and
//   the one-cycle flush (isFlush) with its fetch redirect, and registers
//   results into MEM/WB.
//
// Optional feature:
//   MEM_ALIGN_CHECK_EN - when defined, a misaligned load/store issues no
//   request, raises no stall, pulses align_err and writes wb_ctr_wb = 0.
//   When undefined, align_err is absent, dmem_addr[1:0] is forced to 2'b00
//   and the access proceeds.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   alu_out, reg2_data         EX result / data address, store data
//   write_reg, ctr_m, ctr_wb   destination reg, MEM control, WB control
//   bht_token                  2-bit prediction counter ([1] = predicted taken)
//   pc, pc_branch, pc_jump,
//   pc_next                    instruction PC and candidate targets
//   icache_stall               instruction-side stall
//   dmem_req/we/addr/wdata     data request channel
//   dmem_ack, dmem_rdata       data acknowledge / load data
//   isCacheStall, isFlush      global hold, squash pulse
//   pc_redirect                fetch target, valid with isFlush
//   bht_upd_en/pc/cnt          BHT update strobe, PC, new counter
//   wb_result/write_reg/ctr_wb MEM/WB registers
//   align_err                  misalignment pulse (MEM_ALIGN_CHECK_EN only)

module mem_access #(
    parameter logic [4:0] REG_LINK = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg2_data,
    input  logic [4:0]  write_reg,
    input  logic [5:0]  ctr_m,
    input  logic [1:0]  ctr_wb,
    input  logic [1:0]  bht_token,
    input  logic [31:0] pc,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_jump,
    input  logic [31:0] pc_next,
    input  logic        icache_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        isCacheStall,
    output logic        isFlush,
    output logic [31:0] pc_redirect,
    output logic        bht_upd_en,
    output logic [31:0] bht_upd_pc,
    output logic [1:0]  bht_upd_cnt,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_write_reg,
    output logic [1:0]  wb_ctr_wb
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    // Jump type encodings carried in ctr_m[5:4]
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_JR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] cap_q;

    logic        flush_q,      flush_d;
    logic [31:0] redirect_q,   redirect_d;
    logic        bht_en_q,     bht_en_d;
    logic [31:0] bht_pc_q,     bht_pc_d;
    logic [1:0]  bht_cnt_q,    bht_cnt_d;
    logic [31:0] wb_result_q,  wb_result_d;
    logic [4:0]  wb_reg_q,     wb_reg_d;
    logic [1:0]  wb_ctr_q,     wb_ctr_d;

    // Decode
    logic        mem_op_raw;
    logic        mem_op;
    logic        misalign;
    logic        ctrl_ok;
    logic [1:0]  jtype;
    logic        is_jump;
    logic        is_jal;
    logic        is_branch;
    logic        taken;
    logic        mispredict;
    logic [1:0]  cnt_next;
    logic        access;
    logic        dstall;
    logic        stall;
    logic        advance;
    logic [31:0] load_data;

    assign mem_op_raw = ctr_m[2] | ctr_m[1];

`ifdef MEM_ALIGN_CHECK_EN
    logic align_q, align_d;
    assign misalign = mem_op_raw & (alu_out[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned access (when checked) is dropped entirely: no request, no stall.
    assign mem_op = mem_op_raw & ~misalign;

    // A malformed op with both memory and control bits is treated as memory only.
    assign ctrl_ok   = ~mem_op_raw;
    assign jtype     = ctr_m[5:4];
    assign is_jump   = ctrl_ok & (jtype != JUMP_NONE);
    assign is_jal    = ctrl_ok & (jtype == JUMP_JAL);
    assign is_branch = ctrl_ok & ctr_m[3];
    assign taken     = is_branch & ((alu_out == 32'd0) ^ ctr_m[0]);
    assign mispredict = is_branch & (taken != bht_token[1]);

    always_comb begin
        cnt_next = bht_token;
        if (taken) begin
            cnt_next = (bht_token == 2'b11) ? 2'b11 : bht_token + 2'd1;
        end else begin
            cnt_next = (bht_token == 2'b00) ? 2'b00 : bht_token - 2'd1;
        end
    end

    // Request is live from IDLE/WAIT only; DONE means the access already
    // completed and is waiting for the instruction side, so it is never reissued.
    assign access  = mem_op & (state_q != S_DONE) & ~rst;
    assign dstall  = access & ~dmem_ack;
    assign stall   = dstall | (icache_stall & ~rst);
    assign advance = ~stall & ~rst;

    assign isCacheStall = stall;
    assign dmem_req     = access;
    assign dmem_we      = access & ctr_m[1];
    assign dmem_addr    = access ? {alu_out[31:2], 2'b00} : 32'd0;
    assign dmem_wdata   = (access & ctr_m[1]) ? reg2_data : 32'd0;

    // The capture register only matters once the ack has come and gone.
    assign load_data = (state_q == S_DONE) ? cap_q : dmem_rdata;

    // Access FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cap_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        if (!dmem_ack) begin
                            state_q <= S_WAIT;
                        end else if (icache_stall) begin
                            state_q <= S_DONE;
                            cap_q   <= dmem_rdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (icache_stall) begin
                            state_q <= S_DONE;
                            cap_q   <= dmem_rdata;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (!icache_stall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stage results only move when the pipeline advances, so a branch held
    // by a stall produces exactly one BHT update and its flush is deferred.
    always_comb begin
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        bht_en_d    = 1'b0;
        bht_pc_d    = bht_pc_q;
        bht_cnt_d   = bht_cnt_q;
        wb_result_d = wb_result_q;
        wb_reg_d    = wb_reg_q;
        wb_ctr_d    = wb_ctr_q;
`ifdef MEM_ALIGN_CHECK_EN
        align_d     = 1'b0;
`endif
        if (advance) begin
            // The slot after a flush holds a squashed instruction.
            if ((mispredict | is_jump) && !flush_q) begin
                flush_d = 1'b1;
                if (is_jump) begin
                    redirect_d = pc_jump;
                end else begin
                    redirect_d = taken ? pc_branch : pc_next;
                end
            end

            if (is_branch) begin
                bht_en_d  = 1'b1;
                bht_pc_d  = pc;
                bht_cnt_d = cnt_next;
            end

            if (mem_op && ctr_wb[0]) begin
                wb_result_d = load_data;
            end else if (is_jal) begin
                wb_result_d = pc_next;
            end else begin
                wb_result_d = alu_out;
            end
            wb_reg_d = is_jal ? REG_LINK : write_reg;
            wb_ctr_d = misalign ? 2'b00 : ctr_wb;
`ifdef MEM_ALIGN_CHECK_EN
            align_d  = misalign;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q     <= 1'b0;
            redirect_q  <= 32'd0;
            bht_en_q    <= 1'b0;
            bht_pc_q    <= 32'd0;
            bht_cnt_q   <= 2'b00;
            wb_result_q <= 32'd0;
            wb_reg_q    <= 5'd0;
            wb_ctr_q    <= 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
            align_q     <= 1'b0;
`endif
        end else begin
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            bht_en_q    <= bht_en_d;
            bht_pc_q    <= bht_pc_d;
            bht_cnt_q   <= bht_cnt_d;
            wb_result_q <= wb_result_d;
            wb_reg_q    <= wb_reg_d;
            wb_ctr_q    <= wb_ctr_d;
`ifdef MEM_ALIGN_CHECK_EN
            align_q     <= align_d;
`endif
        end
    end

    assign isFlush      = flush_q;
    assign pc_redirect  = redirect_q;
    assign bht_upd_en   = bht_en_q;
    assign bht_upd_pc   = bht_pc_q;
    assign bht_upd_cnt  = bht_cnt_q;
    assign wb_result    = wb_result_q;
    assign wb_write_reg = wb_reg_q;
    assign wb_ctr_wb    = wb_ctr_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign align_err    = align_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, reg2_data, pc, pc_branch, pc_jump, pc_next, dmem_rdata;
    logic [4:0]  write_reg;
    logic [5:0]  ctr_m;
    logic [1:0]  ctr_wb, bht_token;
    logic        icache_stall, dmem_ack;
    logic        dmem_req, dmem_we, isCacheStall, isFlush, bht_upd_en;
    logic [31:0] dmem_addr, dmem_wdata, pc_redirect, bht_upd_pc, wb_result;
    logic [1:0]  bht_upd_cnt, wb_ctr_wb;
    logic [4:0]  wb_write_reg;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .reg2_data(reg2_data),
        .write_reg(write_reg), .ctr_m(ctr_m), .ctr_wb(ctr_wb), .bht_token(bht_token),
        .pc(pc), .pc_branch(pc_branch), .pc_jump(pc_jump), .pc_next(pc_next),
        .icache_stall(icache_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .isCacheStall(isCacheStall), .isFlush(isFlush),
        .pc_redirect(pc_redirect), .bht_upd_en(bht_upd_en), .bht_upd_pc(bht_upd_pc),
        .bht_upd_cnt(bht_upd_cnt), .wb_result(wb_result), .wb_write_reg(wb_write_reg),
        .wb_ctr_wb(wb_ctr_wb)
`ifdef MEM_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        alu_out = 0; reg2_data = 0; write_reg = 0; ctr_m = 0; ctr_wb = 0;
        bht_token = 0; pc = 0; pc_branch = 0; pc_jump = 0; pc_next = 0;
        icache_stall = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Reference: 2-bit saturating counter as clamped integer arithmetic
    function automatic logic [1:0] sat(input logic [1:0] t, input bit up);
        int v;
        v = int'(t) + (up ? 1 : -1);
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    task automatic do_branch(input logic [31:0] a, input bit ne, input logic [1:0] tok);
        bit taken, misp;
        nop();
        alu_out = a; ctr_m = {4'b0010, 1'b0, ne}; ctr_wb = 2'b00; bht_token = tok;
        pc = $urandom; pc_branch = $urandom; pc_next = $urandom;
        taken = (a == 0) != ne;
        misp  = taken != tok[1];
        #1 chk("br_stall", 32'(isCacheStall), 0);
        tick();
        chk("br_upd_en", 32'(bht_upd_en), 1);
        chk("br_upd_cnt", 32'(bht_upd_cnt), 32'(sat(tok, taken)));
        chk("br_upd_pc", bht_upd_pc, pc);
        chk("br_flush", 32'(isFlush), 32'(misp));
        if (misp) chk("br_redirect", pc_redirect, taken ? pc_branch : pc_next);
        nop();
        tick();
        chk("br_flush_pulse", 32'(isFlush), 0);
        chk("br_upd_pulse", 32'(bht_upd_en), 0);
    endtask

    initial begin
        logic [31:0] addr, data, exp_prev, aa, jt, pn;
        logic [4:0]  wr;
        int lat, stall_cnt;
        bit req_ok;

        rst = 1'b1;
        nop();
        tick(); tick();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(isCacheStall), 0);
        chk("rst_flush", 32'(isFlush), 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_ctr", 32'(wb_ctr_wb), 0);
        chk("rst_bht_en", 32'(bht_upd_en), 0);
        chk("rst_redirect", pc_redirect, 0);
        rst = 1'b0;

        // ALU pass-through
        for (int i = 0; i < 4; i++) begin
            aa = $urandom; wr = 5'($urandom);
            nop(); alu_out = aa; write_reg = wr; ctr_wb = 2'b10;
            #1 chk("alu_req", 32'(dmem_req), 0);
            tick();
            chk("alu_result", wb_result, aa);
            chk("alu_reg", 32'(wb_write_reg), 32'(wr));
            chk("alu_ctr", 32'(wb_ctr_wb), 32'h2);
        end

        // Zero-wait loads
        for (int i = 0; i < 4; i++) begin
            addr = (i == 0) ? 32'h200 : ($urandom & 32'hFFFF_FFFC);
            data = (i == 0) ? 32'hDEADBEEF : $urandom;
            wr = 5'($urandom);
            nop(); alu_out = addr; write_reg = wr; ctr_m = 6'b000100; ctr_wb = 2'b11;
            dmem_ack = 1; dmem_rdata = data;
            #1;
            chk("ld_req", 32'(dmem_req), 1);
            chk("ld_we", 32'(dmem_we), 0);
            chk("ld_addr", dmem_addr, addr);
            chk("ld_stall", 32'(isCacheStall), 0);
            tick();
            chk("ld_result", wb_result, data);
            chk("ld_ctr", 32'(wb_ctr_wb), 32'h3);
            chk("ld_reg", 32'(wb_write_reg), 32'(wr));
        end

        // Stores with delayed ack
        exp_prev = 0;
        for (int i = 0; i < 3; i++) begin
            lat  = (i == 0) ? 3 : int'($urandom_range(1, 5));
            addr = (i == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
            data = $urandom;
            nop(); alu_out = addr; reg2_data = data; ctr_m = 6'b000010;
            stall_cnt = 0; req_ok = 1;
            for (int c = 0; c < lat; c++) begin
                #1;
                if (isCacheStall) stall_cnt++;
                if (!(dmem_req && dmem_we && dmem_addr == addr && dmem_wdata == data)) req_ok = 0;
                tick();
            end
            dmem_ack = 1;
            #1;
            chk("st_ack_stall", 32'(isCacheStall), 0);
            chk("st_ack_req", 32'(dmem_req), 1);
            tick();
            chk("st_stall_cycles", 32'(stall_cnt), 32'(lat));
            chk("st_req_stable", 32'(req_ok), 1);
            exp_prev = addr;
        end

        // Load acked while the instruction side keeps stalling
        data = $urandom; addr = $urandom & 32'hFFFF_FFFC;
        nop(); alu_out = addr; ctr_m = 6'b000100; ctr_wb = 2'b11;
        dmem_ack = 1; dmem_rdata = data; icache_stall = 1;
        #1;
        chk("ov_req", 32'(dmem_req), 1);
        chk("ov_stall", 32'(isCacheStall), 1);
        tick();
        dmem_ack = 0; dmem_rdata = ~data;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ov_done_req", 32'(dmem_req), 0);
            chk("ov_done_stall", 32'(isCacheStall), 1);
            chk("ov_wb_hold", wb_result, exp_prev);
            tick();
        end
        icache_stall = 0;
        #1;
        chk("ov_rel_stall", 32'(isCacheStall), 0);
        chk("ov_rel_req", 32'(dmem_req), 0);
        tick();
        chk("ov_result", wb_result, data);

        // Branches
        do_branch(32'd0, 1'b0, 2'b01);
        for (int i = 0; i < 8; i++) begin
            aa = ($urandom_range(0, 1) == 1) ? 32'd0 : ($urandom | 32'h1);
            do_branch(aa, 1'($urandom), 2'($urandom));
        end

        // Mispredicted branch held by an instruction-side stall
        nop(); alu_out = 0; ctr_m = 6'b001000; bht_token = 2'b00;
        pc_branch = $urandom; icache_stall = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("dfr_flush", 32'(isFlush), 0);
            chk("dfr_upd", 32'(bht_upd_en), 0);
        end
        icache_stall = 0;
        tick();
        chk("dfr_flush_rel", 32'(isFlush), 1);
        chk("dfr_upd_rel", 32'(bht_upd_en), 1);
        chk("dfr_redirect", pc_redirect, pc_branch);
        chk("dfr_cnt", 32'(bht_upd_cnt), 32'h1);
        nop();
        tick();
        chk("dfr_flush_once", 32'(isFlush), 0);

        // JR
        nop(); ctr_m = 6'b110000; pc_jump = 32'h0040_0010;
        tick();
        chk("jr_flush", 32'(isFlush), 1);
        chk("jr_redirect", pc_redirect, 32'h0040_0010);
        nop();
        tick();
        chk("jr_flush_pulse", 32'(isFlush), 0);

        // JAL
        jt = $urandom; pn = $urandom;
        nop(); ctr_m = 6'b100000; ctr_wb = 2'b10; pc_jump = jt; pc_next = pn;
        write_reg = 5'd3; alu_out = $urandom;
        tick();
        chk("jal_reg", 32'(wb_write_reg), 31);
        chk("jal_result", wb_result, pn);
        chk("jal_flush", 32'(isFlush), 1);
        chk("jal_redirect", pc_redirect, jt);
        // Still presenting a jump: flush may not repeat on the next cycle
        tick();
        chk("jal_no_b2b_flush", 32'(isFlush), 0);
        nop();
        tick();

        // Misaligned load
        data = $urandom;
        nop(); alu_out = 32'h102; ctr_m = 6'b000100; ctr_wb = 2'b11;
        dmem_ack = 1; dmem_rdata = data;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        chk("al_req", 32'(dmem_req), 0);
        chk("al_stall", 32'(isCacheStall), 0);
        tick();
        chk("al_err", 32'(align_err), 1);
        chk("al_ctr", 32'(wb_ctr_wb), 0);
        nop();
        tick();
        chk("al_err_pulse", 32'(align_err), 0);
`else
        #1;
        chk("al_req", 32'(dmem_req), 1);
        chk("al_addr", dmem_addr, 32'h100);
        tick();
        chk("al_result", wb_result, data);
        nop();
        tick();
`endif

        // Reset while waiting for ack
        nop(); alu_out = 32'h300; ctr_m = 6'b000100; ctr_wb = 2'b11;
        #1 chk("rw_req", 32'(dmem_req), 1);
        tick();
        chk("rw_wait_stall", 32'(isCacheStall), 1);
        rst = 1'b1;
        tick();
        chk("rw_req_drop", 32'(dmem_req), 0);
        chk("rw_stall", 32'(isCacheStall), 0);
        chk("rw_result", wb_result, 0);
        chk("rw_reg", 32'(wb_write_reg), 0);
        chk("rw_ctr", 32'(wb_ctr_wb), 0);
        chk("rw_flush", 32'(isFlush), 0);
        chk("rw_upd", 32'(bht_upd_en), 0);
        chk("rw_redirect", pc_redirect, 0);
        rst = 1'b0;
        nop();
        tick();
        chk("rw_after_req", 32'(dmem_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
